pll_reset_controller: RTL

Consumes the raw outputs of the 96 MHz system PLL: its asynchronous `locked` flag and a 12 MHz-domain reference toggle. Produces a clean, glitch-free system reset that deasserts synchronously to the 96 MHz clock. Supervises lock loss and clock-ratio errors, and counts lock-loss events. Sits between the PLL wrapper and every 96 MHz-domain block in the design.

---
 rtl/pll_mon_pkg.sv | 22 ++
 rtl/sync_ff.sv | 23 ++
 rtl/pll_reset_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pll_mon_pkg.sv
// Shared state encoding and default parameter values for the PLL reset controller.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        WAIT  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_FAULT_HOLD     = 16;
    localparam int DEF_WINDOW         = 256;
    localparam int DEF_EXPECTED_EDGES = 32;
    localparam int DEF_TOLERANCE      = 2;
    localparam int DEF_LOSS_CNT_W     = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop bit synchronizer for bringing an asynchronous level into the clock domain.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/pll_reset_controller.sv
// Qualifies PLL lock and reference frequency, then releases a registered system reset;
// supervises lock loss / ratio errors and counts lock-loss events.
module pll_reset_controller
    import pll_mon_pkg::*;
#(
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int FAULT_HOLD     = DEF_FAULT_HOLD,
    parameter int WINDOW         = DEF_WINDOW,
    parameter int EXPECTED_EDGES = DEF_EXPECTED_EDGES,
    parameter int TOLERANCE      = DEF_TOLERANCE,
    parameter int LOSS_CNT_W     = DEF_LOSS_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  locked_async,
    input  logic                  ref_toggle,
    input  logic                  clear_count,
    output logic                  sys_reset_n,
    output logic                  pll_ok,
    output logic                  freq_fault,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int SW = cnt_width(STABLE_CYCLES);
    localparam int HW = cnt_width(FAULT_HOLD);
    localparam int WW = cnt_width(WINDOW);
    localparam int EW = $clog2(2 * EXPECTED_EDGES) + 1;

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(FAULT_HOLD - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW - 1);

    state_t          state, next_state;
    logic [SW-1:0]   stable_cnt, stable_next;
    logic [HW-1:0]   hold_cnt, hold_next;
    logic [WW-1:0]   win_cnt;
    logic [EW-1:0]   edge_cnt;
    logic            locked_s;
    logic            ref_s2, ref_s3, ref_edge;
    logic            wrap, out_of_tol, win_fault, loss_inc;
    int              edge_dev;

    sync_ff #(.DEPTH(2)) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (locked_async),
        .q       (locked_s)
    );

    sync_ff #(.DEPTH(2)) u_ref_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (ref_toggle),
        .q       (ref_s2)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ref_s3 <= 1'b0;
        end else begin
            ref_s3 <= ref_s2;
        end
    end

    assign ref_edge = ref_s2 ^ ref_s3;

    // Frequency checker: free-running window, verdict taken on the wrap cycle.
    assign wrap = (win_cnt == WIN_LAST);

    always_comb begin
        edge_dev   = int'(edge_cnt) - EXPECTED_EDGES;
        out_of_tol = (edge_dev > TOLERANCE) || (edge_dev < -TOLERANCE);
    end

    assign win_fault = wrap && out_of_tol;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            freq_fault <= 1'b0;
        end else begin
            if (wrap) begin
                win_cnt    <= '0;
                freq_fault <= out_of_tol;
                // an edge landing in the wrap cycle belongs to the next window
                edge_cnt   <= ref_edge ? EW'(1) : '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                if (ref_edge && (edge_cnt != '1)) begin
                    edge_cnt <= edge_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state  = state;
        stable_next = stable_cnt;
        hold_next   = '0;
        loss_inc    = 1'b0;
        case (state)
            HOLD: begin
                stable_next = '0;
                next_state  = WAIT;
            end
            WAIT: begin
                if (!locked_s || win_fault) begin
                    stable_next = '0;
                end else if (stable_cnt == STABLE_LAST) begin
                    stable_next = '0;
                    next_state  = RUN;
                end else begin
                    stable_next = stable_cnt + 1'b1;
                end
            end
            RUN: begin
                stable_next = '0;
                if (!locked_s) begin
                    next_state = FAULT;
                    loss_inc   = 1'b1;
                end else if (win_fault) begin
                    next_state = FAULT;
                end
            end
            FAULT: begin
                stable_next = '0;
                if (hold_cnt == HOLD_LAST) begin
                    next_state = WAIT;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            default: begin
                next_state = HOLD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HOLD;
            stable_cnt  <= '0;
            hold_cnt    <= '0;
            sys_reset_n <= 1'b0;
        end else begin
            state       <= next_state;
            stable_cnt  <= stable_next;
            hold_cnt    <= hold_next;
            // release lags RUN entry by one cycle; any exit drops it on the same edge
            sys_reset_n <= (state == RUN) && (next_state == RUN);
        end
    end

    assign pll_ok = (state == RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            loss_count <= '0;
        end else if (clear_count) begin
            loss_count <= loss_inc ? LOSS_CNT_W'(1) : '0;
        end else if (loss_inc && (loss_count != '1)) begin
            loss_count <= loss_count + 1'b1;
        end
    end

endmodule
